// File: rtl/timing_pkg.sv
// Shared types and defaults for the beat/phase timing generator and its decoders.
package timing_pkg;

    typedef enum logic [1:0] {
        TG_RUN     = 2'd0,
        TG_STOPPED = 2'd1,
        TG_STEP    = 2'd2
    } tg_state_e;

    localparam int TG_DEF_N_PHASE = 8;
    localparam int TG_DEF_MC_W    = 16;

endpackage

// File: rtl/timing_generator_if.sv
// Control/status bundle between the timing generator (slave) and the control unit (master).
// The step signal exists only when TG_SINGLE_STEP_EN is defined.
interface timing_generator_if
    import timing_pkg::*;
#(
    parameter int N_PHASE = TG_DEF_N_PHASE,
    parameter int MC_W    = TG_DEF_MC_W
);
    localparam int PH_W = $clog2(N_PHASE);

    // No valid/ready here: halt is a level request sampled at every clock edge,
    // cyc_len is sampled at the phase-0 edge, outputs are state decodes valid all cycle.
    logic                 halt;
    logic [PH_W:0]        cyc_len;
`ifdef TG_SINGLE_STEP_EN
    logic                 step;
`endif
    logic [N_PHASE-1:0]   T;
    logic [PH_W-1:0]      phase;
    logic                 cycle_end;
    logic                 halted;
    logic [MC_W-1:0]      mcycle;

`ifdef TG_SINGLE_STEP_EN
    modport master (output halt, cyc_len, step, input T, phase, cycle_end, halted, mcycle);
    modport slave  (input halt, cyc_len, step, output T, phase, cycle_end, halted, mcycle);
`else
    modport master (output halt, cyc_len, input T, phase, cycle_end, halted, mcycle);
    modport slave  (input halt, cyc_len, output T, phase, cycle_end, halted, mcycle);
`endif

endinterface

// File: rtl/timing_generator_phase_decoder.sv
// Binary phase index plus enable to one-hot strobes; also used by the microcontrol decoder.
module phase_decoder #(
    parameter int N_PHASE = 8,
    localparam int PH_W   = $clog2(N_PHASE)
) (
    input  logic [PH_W-1:0]    phase_i,
    input  logic               en_i,
    output logic [N_PHASE-1:0] t_o
);

    always_comb begin
        t_o = '0;
        for (int i = 0; i < N_PHASE; i++) begin
            t_o[i] = en_i && (phase_i == PH_W'(i));
        end
    end

endmodule

// File: rtl/timing_generator.sv
// Beat/phase generator: variable machine-cycle length, halt at cycle boundary.
// Optional single-step mode is enabled by defining TG_SINGLE_STEP_EN.
module timing_generator
    import timing_pkg::*;
#(
    parameter int N_PHASE = TG_DEF_N_PHASE,
    parameter int MC_W    = TG_DEF_MC_W,
    localparam int PH_W   = $clog2(N_PHASE),
    localparam int LEN_W  = PH_W + 1
) (
    input  logic               clk,
    input  logic               rst,
    timing_generator_if.slave  bus,
    output tg_state_e          state_o
);

    tg_state_e        state_q, state_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [MC_W-1:0]  mcycle_q, mcycle_d;
    logic [LEN_W-1:0] len_in;
    logic [LEN_W-1:0] eff;
    logic             last;
    logic             active;
    logic [N_PHASE-1:0] t_onehot;

    // Zero and oversize lengths both mean a full-length machine cycle.
    always_comb begin
        if (bus.cyc_len == '0 || bus.cyc_len > LEN_W'(N_PHASE)) begin
            len_in = LEN_W'(N_PHASE);
        end else begin
            len_in = bus.cyc_len;
        end
    end

    assign eff    = (phase_q == '0) ? len_in : len_q;
    assign last   = ({1'b0, phase_q} == (eff - LEN_W'(1)));
    assign active = (state_q != TG_STOPPED);

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        len_d    = len_q;
        mcycle_d = mcycle_q;
        case (state_q)
            TG_STOPPED: begin
                phase_d = '0;
                if (!bus.halt) begin
                    state_d = TG_RUN;
`ifdef TG_SINGLE_STEP_EN
                end else if (bus.step) begin
                    state_d = TG_STEP;
`endif
                end
            end
            default: begin
                // RUN and STEP advance identically; STEP always stops at its cycle end.
                if (phase_q == '0) begin
                    len_d = len_in;
                end
                if (last) begin
                    phase_d  = '0;
                    mcycle_d = mcycle_q + MC_W'(1);
                    if (state_q == TG_STEP || bus.halt) begin
                        state_d = TG_STOPPED;
                    end
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= TG_RUN;
            phase_q  <= '0;
            len_q    <= LEN_W'(N_PHASE);
            mcycle_q <= '0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            len_q    <= len_d;
            mcycle_q <= mcycle_d;
        end
    end

    phase_decoder #(
        .N_PHASE (N_PHASE)
    ) u_phase_decoder (
        .phase_i (phase_q),
        .en_i    (active),
        .t_o     (t_onehot)
    );

    assign bus.T         = t_onehot;
    assign bus.phase     = phase_q;
    assign bus.cycle_end = last && active;
    assign bus.halted    = !active;
    assign bus.mcycle    = mcycle_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_timing_generator.sv
// Directed bench for timing_generator: phase walk, variable length, clamping, halt, async reset, step.
module tb_timing_generator;
    import timing_pkg::*;

    logic      clk;
    logic      rst;
    tg_state_e state_dbg;
    int        tests_run;
    int        tests_failed;
    logic [31:0] exp_q[$];

    timing_generator_if #(.N_PHASE(8), .MC_W(16)) tg_if ();

    timing_generator #(
        .N_PHASE (8),
        .MC_W    (16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (tg_if),
        .state_o (state_dbg)
    );

    // Clock: posedges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one clock and land 2 time units after the edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Asynchronous reset pulse between clock edges, then let outputs settle.
    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        #1;
    endtask

    task automatic check_out(input string tag, input logic [7:0] t, input logic [2:0] ph,
                             input logic ce, input logic hl, input logic [15:0] mc);
        check({tag, ".T"}, 32'(tg_if.T), 32'(t));
        check({tag, ".phase"}, 32'(tg_if.phase), 32'(ph));
        check({tag, ".cycle_end"}, 32'(tg_if.cycle_end), 32'(ce));
        check({tag, ".halted"}, 32'(tg_if.halted), 32'(hl));
        check({tag, ".mcycle"}, 32'(tg_if.mcycle), 32'(mc));
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        tg_if.halt    = 1'b0;
        tg_if.cyc_len = 4'd8;
`ifdef TG_SINGLE_STEP_EN
        tg_if.step    = 1'b0;
`endif

        // Reset values, no clock yet
        #3;
        check_out("reset", 8'h01, 3'd0, 1'b0, 1'b0, 16'd0);
        check("reset.state", 32'(state_dbg), 32'(TG_RUN));
        #9;
        rst = 1'b0;
        #1;

        // Full-length walk, 20 clocks
        for (int k = 0; k <= 20; k++) begin
            exp_q.push_back(32'(8'h01 << (k % 8)));
        end
        for (int k = 0; k <= 20; k++) begin
            check($sformatf("walk%0d.T", k), 32'(tg_if.T), exp_q.pop_front());
            check($sformatf("walk%0d.ce", k), 32'(tg_if.cycle_end), 32'(k % 8 == 7));
            if (k == 16) check("walk16.mcycle", 32'(tg_if.mcycle), 32'd2);
            if (k < 20) tick(1);
        end

        // Length 5 sampled at phase 0, later change to 2 ignored until next cycle
        tg_if.cyc_len = 4'd5;
        pulse_reset();
        check_out("len5.p0", 8'h01, 3'd0, 1'b0, 1'b0, 16'd0);
        tick(3);
        tg_if.cyc_len = 4'd2;
        #1;
        check_out("len5.p3", 8'h08, 3'd3, 1'b0, 1'b0, 16'd0);
        tick(1);
        check_out("len5.p4", 8'h10, 3'd4, 1'b1, 1'b0, 16'd0);
        tick(1);
        check_out("len2.p0", 8'h01, 3'd0, 1'b0, 1'b0, 16'd1);
        tick(1);
        check_out("len2.p1", 8'h02, 3'd1, 1'b1, 1'b0, 16'd1);
        tick(1);
        check_out("len2.wrap", 8'h01, 3'd0, 1'b0, 1'b0, 16'd2);

        // Clamping: 0 and 12 both act as 8
        tg_if.cyc_len = 4'd0;
        pulse_reset();
        tick(6);
        check_out("len0.p6", 8'h40, 3'd6, 1'b0, 1'b0, 16'd0);
        tick(1);
        check_out("len0.p7", 8'h80, 3'd7, 1'b1, 1'b0, 16'd0);
        tick(1);
        check_out("len0.wrap", 8'h01, 3'd0, 1'b0, 1'b0, 16'd1);
        tg_if.cyc_len = 4'd12;
        pulse_reset();
        tick(7);
        check_out("len12.p7", 8'h80, 3'd7, 1'b1, 1'b0, 16'd0);
        tick(1);
        check_out("len12.wrap", 8'h01, 3'd0, 1'b0, 1'b0, 16'd1);

        // Length 1: cycle_end constant, mcycle every clock
        tg_if.cyc_len = 4'd1;
        pulse_reset();
        check_out("len1.reset", 8'h01, 3'd0, 1'b1, 1'b0, 16'd0);
        tick(1);
        check_out("len1.c1", 8'h01, 3'd0, 1'b1, 1'b0, 16'd1);
        tick(1);
        check_out("len1.c2", 8'h01, 3'd0, 1'b1, 1'b0, 16'd2);

        // Halt at phase 2 completes the cycle, then stops; resume after release
        tg_if.cyc_len = 4'd8;
        pulse_reset();
        tick(2);
        tg_if.halt = 1'b1;
        #1;
        check_out("halt.p2", 8'h04, 3'd2, 1'b0, 1'b0, 16'd0);
        tick(5);
        check_out("halt.p7", 8'h80, 3'd7, 1'b1, 1'b0, 16'd0);
        tick(1);
        check_out("halt.stop", 8'h00, 3'd0, 1'b0, 1'b1, 16'd1);
        check("halt.state", 32'(state_dbg), 32'(TG_STOPPED));
        tick(3);
        check_out("halt.held", 8'h00, 3'd0, 1'b0, 1'b1, 16'd1);
        tg_if.halt = 1'b0;
        #1;
        check("halt.release_pre.T", 32'(tg_if.T), 32'h0);
        tick(1);
        check_out("halt.resume", 8'h01, 3'd0, 1'b0, 1'b0, 16'd1);

        // Halt pulse released before the last phase has no effect
        pulse_reset();
        tick(1);
        tg_if.halt = 1'b1;
        tick(2);
        tg_if.halt = 1'b0;
        tick(4);
        check_out("hpulse.p7", 8'h80, 3'd7, 1'b1, 1'b0, 16'd0);
        tick(1);
        check_out("hpulse.wrap", 8'h01, 3'd0, 1'b0, 1'b0, 16'd1);

        // Async reset mid phase 5 (mcycle nonzero), no clock edge involved
        pulse_reset();
        tick(13);
        check_out("arst.pre", 8'h20, 3'd5, 1'b0, 1'b0, 16'd1);
        rst = 1'b1;
        #1;
        check_out("arst.mid", 8'h01, 3'd0, 1'b0, 1'b0, 16'd0);
        rst = 1'b0;
        tick(1);

        // Async reset while stopped
        tg_if.halt = 1'b1;
        pulse_reset();
        tick(8);
        check_out("arst.stopped_pre", 8'h00, 3'd0, 1'b0, 1'b1, 16'd1);
        rst = 1'b1;
        #1;
        check_out("arst.stopped", 8'h01, 3'd0, 1'b0, 1'b0, 16'd0);
        tg_if.halt = 1'b0;
        rst = 1'b0;
        tick(1);

`ifdef TG_SINGLE_STEP_EN
        // Single step of a 3-phase cycle; second pulse during STEP ignored
        tg_if.halt    = 1'b1;
        tg_if.cyc_len = 4'd3;
        pulse_reset();
        tick(3);
        check_out("step.stopped", 8'h00, 3'd0, 1'b0, 1'b1, 16'd1);
        tg_if.step = 1'b1;
        tick(1);
        tg_if.step = 1'b0;
        #1;
        check_out("step.p0", 8'h01, 3'd0, 1'b0, 1'b0, 16'd1);
        check("step.state", 32'(state_dbg), 32'(TG_STEP));
        tg_if.step = 1'b1;
        tick(1);
        tg_if.step = 1'b0;
        #1;
        check_out("step.p1", 8'h02, 3'd1, 1'b0, 1'b0, 16'd1);
        tick(1);
        check_out("step.p2", 8'h04, 3'd2, 1'b1, 1'b0, 16'd1);
        tick(1);
        check_out("step.done", 8'h00, 3'd0, 1'b0, 1'b1, 16'd2);
        tick(2);
        check_out("step.idle", 8'h00, 3'd0, 1'b0, 1'b1, 16'd2);
        tg_if.halt = 1'b0;
        tick(1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/timing_generator.md
# timing_generator

Parametrised beat/phase generator for the CPU model's control unit. It produces a one-hot phase strobe T[N_PHASE-1:0] per machine cycle and supports a per-instruction variable cycle length, halting at a machine-cycle boundary, and an optional single-step mode. It sits between the clock/reset source and the microcontrol decoder, which qualifies its control words with T.

## Interface
- N_PHASE, default 8: phases per full machine cycle; minimum 2.
- MC_W, default 16: machine-cycle counter width.
- PH_W, derived, $clog2(N_PHASE): phase index width.
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- halt  in  1  level halt request, honoured at machine-cycle end
- cyc_len  in  PH_W+1  phases for the current machine cycle; sampled on phase 0
- step  in  1  single-step pulse; present only with TG_SINGLE_STEP_EN
- T  out  N_PHASE  one-hot phase strobes; all zero while stopped
- phase  out  PH_W  binary index of the current phase
- cycle_end  out  1  high during the last phase of a machine cycle
- halted  out  1  high in STOPPED
- mcycle  out  MC_W  completed machine cycles, wraps modulo 2^MC_W

## Operation
- Reset values: state RUN, phase 0, T = 1 (T[0] high), len_q = N_PHASE, mcycle 0, cycle_end 0 (1 only if the effective length is 1), halted 0.
- States: RUN, STOPPED, plus STEP with the macro.
- Effective length eff = cyc_len when phase == 0, else len_q. A value of 0 or greater than N_PHASE is clamped to N_PHASE.
- At the phase 0 edge in RUN/STEP: len_q <= clamped cyc_len. cyc_len changes in later phases are ignored.
- last = (phase == eff-1). cycle_end = last and state != STOPPED.
- RUN, not last: phase <= phase+1.
- RUN, last: phase <= 0 and mcycle <= mcycle+1. If halt is high at that edge, go to STOPPED.
- Halt asserted mid-cycle does not stop the generator until the current machine cycle completes. Halt pulsed and released before last has no effect.
- STOPPED: T = 0, phase held at 0, mcycle held. When halt is low at an edge, go to RUN; T[0] is high in the following cycle.
- T = onehot(phase) in RUN/STEP. Exactly one bit is ever high, never more.
- Async rst at any point, including mid-cycle or while STOPPED, forces the reset values immediately.

## Timing
- One phase per clk; machine cycle length = eff clocks. Full-length period = N_PHASE clocks, matching an 8-stage ring at the defaults.
- Halt latency: from halt high in phase k to T = 0 is (eff-1-k)+1 clocks.
- Resume latency: 1 clock from halt low to T[0].
- cycle_end, T and phase are registered-state decodes, valid the whole cycle. mcycle increments at the edge ending the last phase.
- cyc_len = 1: T[0] every clock, cycle_end constantly high, mcycle increments every clock.

## Configuration
- TG_SINGLE_STEP_EN defined:
  - step port exists.
  - A step high while STOPPED (halt still high) enters STEP.
  - STEP runs exactly one machine cycle, as in RUN, then returns to STOPPED regardless of halt.
  - step is ignored outside STOPPED.
  - If halt is low at the same edge as step, RUN takes priority.
- TG_SINGLE_STEP_EN undefined: no step port, no STEP state; STOPPED exits only via halt low.

## Structure
- Shared package timing_pkg: state enum (TG_RUN, TG_STOPPED, TG_STEP), TG_DEF_N_PHASE = 8, TG_DEF_MC_W = 16.
- Sub-module phase_decoder: combinational, binary phase plus enable to one-hot T. Reused by the microcontrol decoder.
- Top block holds the state register, phase counter, len_q and mcycle.

## Test plan
- Reset, then halt = 0 and cyc_len = 8 for 20 clocks -> T walks 1, 2, 4 … 128, 1; cycle_end high on T[7] only; mcycle = 2 after 16 clocks.
- cyc_len = 5 at phase 0, changed to 2 at phase 3 -> phases 0–4 run, wrap after T[4], then next cycle uses 2.
- cyc_len = 0 and cyc_len = 12 -> both behave as 8-phase cycles.
- halt high at phase 2, cyc_len = 8 -> T continues to T[7], then T = 0 and halted = 1. Release halt -> T[0] one clock later; mcycle unchanged while stopped.
- Async rst asserted mid-phase 5 and while STOPPED -> T = 1, mcycle = 0, halted = 0 immediately, without a clock.
- With TG_SINGLE_STEP_EN, stopped, step pulse, cyc_len = 3 -> T[0], T[1], T[2], then back to T = 0; mcycle +1; a second pulse during STEP is ignored.
